ram_loader: RTL
===============

Name: ram_loader

Overview:
Upstream stage of the `ram` block. It receives a program/data image as a byte stream over a valid/ready handshake and writes it sequentially into RAM, filling every address from 0 to 2**AW-1. While loading it accumulates a modulo-2**DW checksum. An optional verify pass reads the RAM back and compares checksums. It drives the RAM's `addr`/`w`/`data_in` pins and observes `data_out`.

Parameters:
- AW, 5, RAM address width; load length DEPTH = 2**AW words.
- DW, 8, data width of stream and RAM words.
- RD_LAT, 1, RAM read latency in clocks (0 = combinational read, 1 = registered read); only values 0 and 1 are legal.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a load; ignored while busy.
- in_valid, input, 1, stream byte valid.
- in_data, input, DW, stream byte.
- in_ready, output, 1, loader accepts a byte this cycle.
- ram_addr, output, AW, to RAM `addr`.
- ram_w, output, 1, to RAM `w` (write enable).
- ram_in, output, DW, to RAM `data_in`.
- ram_out, input, DW, from RAM `data_out`.
- busy, output, 1, high in LOAD/FLUSH/VERIFY.
- done, output, 1, load (and verify if enabled) succeeded; held until the next start or rst.
- error, output, 1, verify checksum mismatch; held until the next start or rst.
- checksum, output, DW, load checksum (sum of accepted bytes, mod 2**DW).

Behaviour:
- Reset (rst=1 at an edge) has the following results:
  - State goes to IDLE.
  - ram_addr=0, ram_w=0, ram_in=0, in_ready=0, busy=0, done=0, error=0, checksum=0.
  - Reset mid-operation aborts immediately; ram_w is 0 from the cycle after the reset edge. RAM contents are not cleared.
- States are IDLE, LOAD, FLUSH, VERIFY, DONE, ERR.
- IDLE/DONE/ERR:
  - start=1 → LOAD.
  - The index counter (AW+1 bits) and checksum are cleared, and done/error go to 0.
  - in_ready=0.
  - in_valid is ignored.
- LOAD:
  - in_ready=1 (combinational from state).
  - A byte transfers when in_valid&&in_ready at an edge.
  - On each transfer, the registered outputs update at that edge: ram_w=1, ram_in=in_data, ram_addr=index[AW-1:0]. Also checksum+=in_data (wraps mod 2**DW) and index+=1.
  - The RAM commits the byte at the next edge, so the write lands 1 cycle after acceptance.
  - With no transfer, ram_w=0 at the next edge. Bubbles are allowed; back-to-back transfers give one byte per cycle.
  - start is ignored.
- The transfer with index==DEPTH-1 moves the FSM to FLUSH. In FLUSH, the last write is on the pins for exactly one cycle and in_ready=0.
- FLUSH → VERIFY (feature enabled) or FLUSH → DONE (feature disabled), after one cycle.
- VERIFY:
  - ram_w=0.
  - ram_addr steps 0..DEPTH-1, one address per cycle.
  - The readback for an address is sampled RD_LAT cycles after that address is driven, and readback data is summed mod 2**DW.
  - After DEPTH samples, the FSM goes to DONE if the readback sum equals checksum, otherwise to ERR.
- DONE: done=1, busy=0. ERR: error=1, busy=0.
- Address wrap: index bit AW marks completion. ram_addr never exceeds DEPTH-1, and no write past the last address is ever issued.
- A start pulse coinciding with rst is ignored; rst wins.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined: the VERIFY state and readback adder are compiled in. The flow is FLUSH→VERIFY→DONE/ERR, and error can assert.
- Undefined: VERIFY logic is absent and ram_out is unused. The flow is FLUSH→DONE, and error is tied to 0.

Test Plan:
1. rst held 2 cycles, then released → all outputs 0 and FSM in IDLE; in_valid=1 while IDLE → in_ready=0 and no ram_w pulse.
2. start, then bytes 0x00..0x1F streamed back-to-back (AW=5, DW=8, RD_LAT=1) → the required results are:
   - 32 consecutive ram_w pulses, each 1 cycle after its acceptance, with ram_addr=i and ram_in=i.
   - checksum=0xF0.
   - With LOADER_VERIFY_EN, done=1 and error=0 exactly DEPTH+RD_LAT+2 cycles after the last accept (±0 measured by the bench).
   - A RAM readback of addresses 0..31 returns 0..31.
3. Same image with in_valid toggling every other cycle → identical RAM contents and checksum; ram_w is low during every bubble.
4. With LOADER_VERIFY_EN, the bench corrupts RAM address 7 (forces 0xAA) during FLUSH → error=1, done=0, checksum still 0xF0.
5. rst asserted after 10 bytes are accepted → ram_w=0 from the next cycle, FSM in IDLE. A following start and a full 32-byte load complete normally with done=1.
6. start pulsed mid-LOAD, and all-0xFF image → the mid-LOAD start is ignored (index continues). For the all-0xFF image, checksum=0xE0 (32×0xFF mod 256) and done=1.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: streams a DEPTH = 2**AW word image into a single-port RAM.
//
// Bytes arrive on a valid/ready stream and are written to addresses
// 0..DEPTH-1 in order, one RAM write per accepted byte. A checksum of the
// accepted bytes (mod 2**DW) is kept. When the macro LOADER_VERIFY_EN is
// defined, a verify pass reads the whole RAM back, sums the readback data
// and compares the sum with the load checksum. Without it the flow ends after
// the last write, ram_out is unused and error never asserts.
//
// Parameters:
//   AW     - RAM address width (DEPTH = 2**AW words per load)
//   DW     - stream and RAM word width
//   RD_LAT - RAM read latency in clocks, 0 (combinational) or 1 (registered)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   start    - one-cycle pulse that begins a load, ignored while busy
//   in_valid - stream byte valid
//   in_data  - stream byte
//   in_ready - loader accepts a byte this cycle
//   ram_addr - RAM address
//   ram_w    - RAM write enable
//   ram_in   - RAM write data
//   ram_out  - RAM read data
//   busy     - high while loading, flushing or verifying
//   done     - load (and verify, when present) succeeded; held until start/rst
//   error    - verify checksum mismatch; held until start/rst
//   checksum - sum of accepted bytes, mod 2**DW

module ram_loader #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_w,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);
  localparam logic [AW:0] IDX_LAST = (AW+1)'(DEPTH - 1);

  if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_rd_lat
    $error("ram_loader: RD_LAT must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  // One bit wider than the address so that bit AW flags "all DEPTH words seen".
  logic [AW:0] index;

  // The index guard keeps a write past the last address impossible even if
  // the state register were ever caught in LOAD with a full count.
  assign in_ready = (state == S_LOAD) && !index[AW];
  assign busy     = (state == S_LOAD) || (state == S_FLUSH) || (state == S_VERIFY);

`ifdef LOADER_VERIFY_EN
  logic [AW:0]   vidx;    // next address to issue during verify
  logic          addr_v;  // ram_addr carries a verify address this cycle
  logic          rd_v;    // that address, delayed one cycle for a registered read
  logic          samp_v;  // ram_out holds readback data to sum at this edge
  logic [AW:0]   scount;  // readback samples summed so far
  logic [DW-1:0] rb_sum;

  assign samp_v = (RD_LAT == 0) ? addr_v : rd_v;
`else
  logic unused_ram_out;
  assign unused_ram_out = ^ram_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge value of every other register.
      state    <= S_IDLE;
      index    <= '0;
      ram_addr <= '0;
      ram_w    <= 1'b0;
      ram_in   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
`ifdef LOADER_VERIFY_EN
      vidx     <= '0;
      addr_v   <= 1'b0;
      rd_v     <= 1'b0;
      scount   <= '0;
      rb_sum   <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless a transfer renews it.
      ram_w <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LOAD;
            index    <= '0;
            checksum <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end

        S_LOAD: begin
          if (in_valid && in_ready) begin
            ram_w    <= 1'b1;
            ram_in   <= in_data;
            ram_addr <= index[AW-1:0];
            checksum <= checksum + in_data;
            index    <= index + IDX_ONE;
            if (index == IDX_LAST) begin
              state <= S_FLUSH;
            end
          end
        end

        // The final write sits on the RAM pins during this cycle.
        S_FLUSH: begin
`ifdef LOADER_VERIFY_EN
          state    <= S_VERIFY;
          ram_addr <= '0;
          vidx     <= IDX_ONE;
          addr_v   <= 1'b1;
          rd_v     <= 1'b0;
          scount   <= '0;
          rb_sum   <= '0;
`else
          state <= S_DONE;
          done  <= 1'b1;
`endif
        end

`ifdef LOADER_VERIFY_EN
        // Issue one address per cycle, sum each readback RD_LAT cycles later,
        // and compare one cycle after the last sample has been summed.
        S_VERIFY: begin
          rd_v <= addr_v;
          if (samp_v) begin
            rb_sum <= rb_sum + ram_out;
            scount <= scount + IDX_ONE;
          end
          if (!vidx[AW]) begin
            ram_addr <= vidx[AW-1:0];
            vidx     <= vidx + IDX_ONE;
            addr_v   <= 1'b1;
          end else begin
            addr_v <= 1'b0;
          end
          if (scount[AW]) begin
            if (rb_sum == checksum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
